// File: rtl/poly_eval_ctrl.sv
// poly_eval_ctrl: two-requester round-robin front end for a fixed-latency
// polynomial datapath. One evaluation in flight at a time:
// IDLE -> ISSUE -> WAIT (DP_LAT cycles) -> RESP -> IDLE.
// All outputs are registered and change together with the state.
module poly_eval_ctrl #(
   parameter int DP_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [14:0] x0,
   input  logic [14:0] x1,
   input  logic [6:0]  seg0,
   input  logic [6:0]  seg1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        dp_en,
   output logic [14:0] dp_dataa,
   output logic [6:0]  dp_segment,
   input  logic [15:0] dp_result,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // The counter runs DP_LAT-1 down to 0, so WAIT lasts exactly DP_LAT cycles.
   localparam logic [3:0] WAIT_LOAD = 4'(DP_LAT - 1);

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        last_id_reg;
   logic        gnt0_reg;
   logic        gnt1_reg;
   logic        dp_en_reg;
   logic [14:0] opnd_x_reg;
   logic [6:0]  opnd_seg_reg;
   logic        rsp_valid_reg;
   logic        rsp_id_reg;
   logic [15:0] rsp_data_reg;
   logic        busy_reg;
   logic [15:0] op_count_reg;

   // Round-robin pick: requester 1 wins when it is alone, or when both are
   // requesting and requester 0 was the most recent winner.
   logic pick1;
   assign pick1 = req1 & (~req0 | ~last_id_reg);

   // Controller FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         last_id_reg   <= 1'b1;
         gnt0_reg      <= 1'b0;
         gnt1_reg      <= 1'b0;
         dp_en_reg     <= 1'b0;
         opnd_x_reg    <= 15'd0;
         opnd_seg_reg  <= 7'd0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_data_reg  <= 16'd0;
         busy_reg      <= 1'b0;
         op_count_reg  <= 16'd0;
      end else begin
         // Strobes are single-cycle by default.
         gnt0_reg      <= 1'b0;
         gnt1_reg      <= 1'b0;
         dp_en_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req0 || req1) begin
                  opnd_x_reg   <= pick1 ? x1 : x0;
                  opnd_seg_reg <= pick1 ? seg1 : seg0;
                  last_id_reg  <= pick1;
                  // Grant and start strobe are visible during the ISSUE cycle.
                  gnt0_reg     <= ~pick1;
                  gnt1_reg     <= pick1;
                  dp_en_reg    <= 1'b1;
                  busy_reg     <= 1'b1;
                  state_reg    <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_reg   <= WAIT_LOAD;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (cnt_reg == 4'd0) begin
                  rsp_data_reg  <= dp_result;
                  rsp_valid_reg <= 1'b1;
                  rsp_id_reg    <= last_id_reg;
                  op_count_reg  <= op_count_reg + 16'd1;
                  state_reg     <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign gnt0       = gnt0_reg;
   assign gnt1       = gnt1_reg;
   assign dp_en      = dp_en_reg;
   assign dp_dataa   = opnd_x_reg;
   assign dp_segment = opnd_seg_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = rsp_id_reg;
   assign rsp_data   = rsp_data_reg;
   assign busy       = busy_reg;
   assign op_count   = op_count_reg;

endmodule
